trigger_scheduler: RTL and testbench

TRIGGER_SCHEDULER -- requirements
Module: trigger_scheduler

---
 rtl/trigger_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_trigger_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_scheduler.sv
//------------------------------------------------------------------------------
// trigger_scheduler
//
// Generates a periodic camera/illumination frame trigger. A frame lasts
// `period` clk_48MHz cycles; trig_out is high for the first `width` cycles of
// each frame and frame_strobe pulses on the first cycle of each frame.
// New (period, width) pairs arrive through a one-deep pending slot and are
// applied only on frame boundaries while running, so a frame in flight is
// never altered. A stop request never truncates a trigger pulse that is
// already high: the block drains until the pulse ends, then goes idle.
//
// Ports
//   clk_48MHz     in   sole clock, rising edge
//   reset         in   synchronous, active-high reset
//   start         in   level; begin triggering (IDLE only, stop has priority)
//   stop          in   level; end triggering
//   cfg_valid     in   new configuration offered
//   cfg_ready     out  pending slot empty, configuration can be taken
//   cfg_period    in   requested frame period in cycles
//   cfg_width     in   requested trigger high time in cycles
//   cfg_err       out  one-cycle pulse after a rejected configuration
//   trig_out      out  frame trigger (registered)
//   frame_strobe  out  one-cycle pulse on the first cycle of a frame (registered)
//   frame_count   out  frames started since the last accepted start
//   running       out  high while in RUN or DRAIN
//------------------------------------------------------------------------------
module trigger_scheduler #(
  parameter int CNT_W      = 21,
  parameter int DEF_PERIOD = 1200000,
  parameter int DEF_WIDTH  = 24000
) (
  input  logic             clk_48MHz,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  output logic             cfg_err,
  output logic             trig_out,
  output logic             frame_strobe,
  output logic [15:0]      frame_count,
  output logic             running
);

  localparam logic [CNT_W-1:0] L_DEF_PERIOD = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] L_DEF_WIDTH  = CNT_W'(DEF_WIDTH);
  localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_TWO        = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_period;       // active period
  logic [CNT_W-1:0] r_width;        // active width
  logic [CNT_W-1:0] r_drain_end;    // width of the frame being drained
  logic             r_pend_valid;
  logic [CNT_W-1:0] r_pend_period;
  logic [CNT_W-1:0] r_pend_width;
  logic             r_trig;
  logic             r_strobe;
  logic [15:0]      r_fcount;
  logic             r_cfg_err;

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  state_t           w_state_next;
  logic [CNT_W-1:0] w_phase_next;
  logic [CNT_W-1:0] w_period_next;
  logic [CNT_W-1:0] w_width_next;
  logic [CNT_W-1:0] w_drain_end_next;
  logic             w_pend_valid_next;
  logic [CNT_W-1:0] w_pend_period_next;
  logic [CNT_W-1:0] w_pend_width_next;
  logic             w_trig_next;
  logic             w_strobe_next;
  logic [15:0]      w_fcount_next;
  logic             w_cfg_err_next;

  // Helpers
  logic             w_cfg_take;     // handshake completes this cycle
  logic             w_cfg_ok;       // offered pair is legal
  logic             w_load;         // pending slot moves to active this cycle
  logic [CNT_W-1:0] w_width_eff;    // width governing a frame that starts now
  logic [CNT_W-1:0] w_phase_inc;
  logic             w_wrap;

  assign w_cfg_take  = cfg_valid && !r_pend_valid;
  assign w_cfg_ok    = (cfg_period >= L_TWO) && (cfg_width != '0) &&
                       (cfg_width < cfg_period);
  assign w_phase_inc = r_phase + L_ONE;
  assign w_wrap      = (r_phase == (r_period - L_ONE));
  // A frame starting on the same edge as a load uses the freshly loaded width.
  assign w_width_eff = r_pend_valid ? r_pend_width : r_width;

  always_comb begin
    w_state_next       = r_state;
    w_phase_next       = r_phase;
    w_period_next      = r_period;
    w_width_next       = r_width;
    w_drain_end_next   = r_drain_end;
    w_pend_valid_next  = r_pend_valid;
    w_pend_period_next = r_pend_period;
    w_pend_width_next  = r_pend_width;
    w_trig_next        = 1'b0;
    w_strobe_next      = 1'b0;
    w_fcount_next      = r_fcount;
    w_cfg_err_next     = 1'b0;
    w_load             = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_load       = r_pend_valid;
        w_phase_next = '0;
        // stop has priority over start
        if (start && !stop) begin
          w_state_next  = ST_RUN;
          w_phase_next  = '0;
          w_trig_next   = (w_width_eff != '0);
          w_strobe_next = 1'b1;
          w_fcount_next = 16'd1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          // A high pulse finishes in DRAIN; if it would end on this very
          // edge there is nothing left to drain.
          if (r_trig && (w_phase_inc < r_width)) begin
            w_state_next     = ST_DRAIN;
            w_phase_next     = w_phase_inc;
            w_drain_end_next = r_width;
            w_trig_next      = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
            w_phase_next = '0;
          end
        end else if (w_wrap) begin
          // Frame boundary: the only point a new config may take effect.
          w_load        = r_pend_valid;
          w_phase_next  = '0;
          w_trig_next   = (w_width_eff != '0);
          w_strobe_next = 1'b1;
          w_fcount_next = r_fcount + 16'd1;
        end else begin
          w_phase_next = w_phase_inc;
          w_trig_next  = (w_phase_inc < r_width);
        end
      end

      ST_DRAIN: begin
        // Pulse end is held in r_drain_end, so loading a new width here
        // cannot shorten the pulse being finished.
        w_load = r_pend_valid;
        if (w_phase_inc < r_drain_end) begin
          w_phase_next = w_phase_inc;
          w_trig_next  = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
          w_phase_next = '0;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_phase_next = '0;
      end
    endcase

    if (w_load) begin
      w_period_next     = r_pend_period;
      w_width_next      = r_pend_width;
      w_pend_valid_next = 1'b0;
    end

    // Slot is empty whenever a handshake can complete, so this never
    // collides with the load above.
    if (w_cfg_take) begin
      if (w_cfg_ok) begin
        w_pend_valid_next  = 1'b1;
        w_pend_period_next = cfg_period;
        w_pend_width_next  = cfg_width;
      end else begin
        w_cfg_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48MHz) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_phase       <= '0;
      r_period      <= L_DEF_PERIOD;
      r_width       <= L_DEF_WIDTH;
      r_drain_end   <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_period <= '0;
      r_pend_width  <= '0;
      r_trig        <= 1'b0;
      r_strobe      <= 1'b0;
      r_fcount      <= 16'd0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_phase       <= w_phase_next;
      r_period      <= w_period_next;
      r_width       <= w_width_next;
      r_drain_end   <= w_drain_end_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_period <= w_pend_period_next;
      r_pend_width  <= w_pend_width_next;
      r_trig        <= w_trig_next;
      r_strobe      <= w_strobe_next;
      r_fcount      <= w_fcount_next;
      r_cfg_err     <= w_cfg_err_next;
    end
  end

  assign cfg_ready    = !r_pend_valid;
  assign cfg_err      = r_cfg_err;
  assign trig_out     = r_trig;
  assign frame_strobe = r_strobe;
  assign frame_count  = r_fcount;
  assign running      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_trigger_scheduler.sv
//------------------------------------------------------------------------------
// tb_trigger_scheduler
//
// Cycle-level reference model of the scheduler. Every stepped cycle the model
// predicts the registered outputs after the coming edge; the prediction is
// pushed to a scoreboard queue and popped/compared once the edge has passed.
// Directed checks on top cover the scenario-specific expectations.
//------------------------------------------------------------------------------
module tb_trigger_scheduler;

  localparam int CNT_W   = 21;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic             clk_48MHz = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_width;
  logic             cfg_err;
  logic             trig_out;
  logic             frame_strobe;
  logic [15:0]      frame_count;
  logic             running;

  always #10 clk_48MHz = ~clk_48MHz;

  trigger_scheduler #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (1200000),
    .DEF_WIDTH  (24000)
  ) dut (
    .clk_48MHz    (clk_48MHz),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_width    (cfg_width),
    .cfg_err      (cfg_err),
    .trig_out     (trig_out),
    .frame_strobe (frame_strobe),
    .frame_count  (frame_count),
    .running      (running)
  );

  typedef struct packed {
    logic        trig;
    logic        strobe;
    logic [15:0] fc;
    logic        run;
    logic        ready;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          m_mode, m_ph, m_per, m_wid, m_pp, m_pw, m_dend;
  bit          m_pv, m_trig, m_strobe, m_err;
  logic [15:0] m_fc;

  function automatic void model_step();
    bit take, good, old_pv, use_pend;
    int cp, cw;
    if (reset) begin
      m_mode = M_IDLE; m_ph = 0; m_per = 1200000; m_wid = 24000;
      m_pv = 0; m_fc = 16'd0; m_trig = 0; m_strobe = 0; m_err = 0; m_dend = 0;
      return;
    end
    cp       = int'(cfg_period);
    cw       = int'(cfg_width);
    old_pv   = m_pv;
    take     = cfg_valid && !m_pv;
    good     = (cp >= 2) && (cw != 0) && (cw < cp);
    use_pend = 0;
    m_strobe = 0;
    case (m_mode)
      M_IDLE: begin
        use_pend = old_pv;
        if (use_pend) begin m_per = m_pp; m_wid = m_pw; end
        if (start && !stop) begin
          m_mode = M_RUN; m_ph = 0; m_fc = 16'd1; m_strobe = 1;
        end
      end
      M_RUN: begin
        if (stop) begin
          if (m_trig && (m_ph + 1 < m_wid)) begin
            m_mode = M_DRAIN; m_dend = m_wid; m_ph = m_ph + 1;
          end else begin
            m_mode = M_IDLE; m_ph = 0;
          end
        end else if (m_ph == m_per - 1) begin
          use_pend = old_pv;
          if (use_pend) begin m_per = m_pp; m_wid = m_pw; end
          m_ph = 0; m_fc = m_fc + 16'd1; m_strobe = 1;
        end else begin
          m_ph = m_ph + 1;
        end
      end
      default: begin
        use_pend = old_pv;
        if (use_pend) begin m_per = m_pp; m_wid = m_pw; end
        m_ph = m_ph + 1;
        if (m_ph >= m_dend) begin m_mode = M_IDLE; m_ph = 0; end
      end
    endcase
    if (use_pend) m_pv = 0;
    if (take && good) begin m_pv = 1; m_pp = cp; m_pw = cw; end
    m_err = take && !good;
    if (m_mode == M_IDLE)       m_trig = 0;
    else if (m_mode == M_DRAIN) m_trig = (m_ph < m_dend);
    else                        m_trig = (m_ph < m_wid);
  endfunction

  // One clock: predict, push, advance, pop, compare.
  task automatic step(input bit chk);
    exp_t e;
    model_step();
    if (chk) begin
      e.trig   = m_trig;
      e.strobe = m_strobe;
      e.fc     = m_fc;
      e.run    = (m_mode != M_IDLE);
      e.ready  = !m_pv;
      e.err    = m_err;
      sb_q.push_back(e);
    end
    @(posedge clk_48MHz);
    #1;
    if (chk) begin
      e = sb_q.pop_front();
      check("trig_out",     32'(trig_out),     32'(e.trig));
      check("frame_strobe", 32'(frame_strobe), 32'(e.strobe));
      check("frame_count",  32'(frame_count),  32'(e.fc));
      check("running",      32'(running),      32'(e.run));
      check("cfg_ready",    32'(cfg_ready),    32'(e.ready));
      check("cfg_err",      32'(cfg_err),      32'(e.err));
    end
  endtask

  task automatic run_count(input int n, input bit chk, output int highs, output int strobes);
    highs   = 0;
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      step(chk);
      if (trig_out)     highs++;
      if (frame_strobe) strobes++;
    end
  endtask

  task automatic offer_cfg(input int p, input int w);
    $display("[TB] cfg offered period=%0d width=%0d", p, w);
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(p);
    cfg_width  = CNT_W'(w);
    step(1);
    cfg_valid  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          h, s;
    bit          wrap_seen;
    logic [15:0] prev_fc;

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_valid = 1'b0; cfg_period = '0; cfg_width = '0;
    step(1);
    step(1);
    $display("[TB] reset applied");
    check("rst_trig",   32'(trig_out),    32'd0);
    check("rst_fc",     32'(frame_count), 32'd0);
    check("rst_ready",  32'(cfg_ready),   32'd1);
    check("rst_period", 32'(dut.r_period), 32'd1200000);
    check("rst_width",  32'(dut.r_width),  32'd24000);
    reset = 1'b0;
    step(1);

    // Accept (10,3): slot fills for one cycle, then drains into active.
    offer_cfg(10, 3);
    check("ready_low_after_cfg", 32'(cfg_ready), 32'd0);
    step(1);
    check("ready_back", 32'(cfg_ready), 32'd1);
    check("act_period_10", 32'(dut.r_period), 32'd10);

    // Illegal configs: one err pulse each, active values kept.
    offer_cfg(10, 10);
    check("err_10_10", 32'(cfg_err), 32'd1);
    check("ready_after_rej", 32'(cfg_ready), 32'd1);
    step(1);
    check("err_one_cycle", 32'(cfg_err), 32'd0);
    offer_cfg(1, 0);
    check("err_1_0", 32'(cfg_err), 32'd1);
    step(1);
    check("err_clear", 32'(cfg_err), 32'd0);
    check("keep_period", 32'(dut.r_period), 32'd10);
    check("keep_width",  32'(dut.r_width),  32'd3);

    // Start: three frames of (10,3).
    $display("[TB] start (10,3)");
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("start_strobe", 32'(frame_strobe), 32'd1);
    check("start_trig",   32'(trig_out),     32'd1);
    check("start_fc",     32'(frame_count),  32'd1);
    check("start_run",    32'(running),      32'd1);
    run_count(29, 1, h, s);
    check("trig_highs_3frames", 32'(h), 32'd8);
    check("strobes_3frames",    32'(s), 32'd2);
    check("fc_after_3frames",   32'(frame_count), 32'd3);

    // Config (6,2) offered at phase 4 of frame 4; applies at the wrap.
    run_count(5, 1, h, s);
    check("frame4_strobe", 32'(s), 32'd1);
    offer_cfg(6, 2);
    check("ready_low_midframe", 32'(cfg_ready), 32'd0);
    run_count(4, 1, h, s);
    check("old_frame_tail_low", 32'(h), 32'd0);
    check("ready_low_till_wrap", 32'(cfg_ready), 32'd0);
    run_count(12, 1, h, s);
    check("new_frame_highs", 32'(h), 32'd4);
    check("new_frame_strobes", 32'(s), 32'd2);
    check("new_period_6", 32'(dut.r_period), 32'd6);
    check("fc_after_switch", 32'(frame_count), 32'd6);

    // Stop with trigger low (phase 5): idle next cycle.
    $display("[TB] stop at phase 5");
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_low_idle", 32'(running), 32'd0);
    check("stop_fc_hold",  32'(frame_count), 32'd6);

    // Stop at phase 1 with width 3: pulse completes through phase 2.
    offer_cfg(10, 3);
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    $display("[TB] stop at phase 1");
    stop  = 1'b1;
    start = 1'b1;  // ignored while draining
    step(1);
    check("drain_trig_high", 32'(trig_out), 32'd1);
    check("drain_running",   32'(running),  32'd1);
    step(1);
    check("drain_end_trig", 32'(trig_out), 32'd0);
    check("drain_end_idle", 32'(running),  32'd0);
    // start and stop together in IDLE: stays idle.
    step(1);
    check("start_stop_idle", 32'(running), 32'd0);
    stop  = 1'b0;
    start = 1'b0;
    step(1);

    // Reset in the middle of a pulse.
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("pre_reset_trig", 32'(trig_out), 32'd1);
    $display("[TB] reset mid-pulse");
    reset = 1'b1;
    step(1);
    check("mid_rst_trig",   32'(trig_out),    32'd0);
    check("mid_rst_fc",     32'(frame_count), 32'd0);
    check("mid_rst_run",    32'(running),     32'd0);
    check("mid_rst_period", 32'(dut.r_period), 32'd1200000);
    check("mid_rst_width",  32'(dut.r_width),  32'd24000);
    reset = 1'b0;
    step(1);

    // frame_count wrap: no preset exists, so run period 2 until it rolls over.
    offer_cfg(2, 1);
    step(1);
    $display("[TB] long run (2,1) toward frame_count wrap");
    start = 1'b1;
    step(1);
    start = 1'b0;
    run_count(131060, 0, h, s);
    check("fc_before_wrap", 32'(frame_count), 32'h0000FFFB);
    wrap_seen = 1'b0;
    prev_fc   = frame_count;
    h = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (trig_out) h++;
      if (frame_strobe && prev_fc == 16'hFFFF) begin
        check("fc_wrap_zero", 32'(frame_count), 32'd0);
        wrap_seen = 1'b1;
      end
      prev_fc = frame_count;
    end
    check("wrap_seen", 32'(wrap_seen), 32'd1);
    check("wrap_trig_highs", 32'(h), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
